// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the two-client UART transmit arbiter: state encoding,
// default parameter values and the round-robin pick helper.
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_DBIT     = 8;
  localparam int DEF_TOUT     = 1024;
  localparam int DEF_TOUT_BIT = 10;

  // Both valid: alternate away from the last owner; otherwise take whoever asks.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_owner);
    logic pick;
    case (valid)
      2'b11:   pick = ~last_owner;
      2'b10:   pick = 1'b1;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arb_counter.sv
// Free-running mod-M counter with a synchronous clear; used as the arbiter's
// stall-timeout timer.
module counter #(
  parameter int M = 10,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic [N-1:0] q,
  output logic         max_tick
);

  logic [N-1:0] q_r;

  // Count modulo M; clear wins over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= {N{1'b0}};
    end else if (clr) begin
      q_r <= {N{1'b0}};
    end else if (q_r == N'(M - 1)) begin
      q_r <= {N{1'b0}};
    end else begin
      q_r <= q_r + N'(1);
    end
  end

  assign q        = q_r;
  assign max_tick = (q_r == N'(M - 1));

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter giving two byte clients exclusive use of a
// UART transmit FIFO, with a stall timeout that drops a hung packet.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int DBIT     = DEF_DBIT,
  parameter int TOUT     = DEF_TOUT,
  parameter int TOUT_BIT = DEF_TOUT_BIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_last,
  input  logic [DBIT-1:0] req_data0,
  input  logic [DBIT-1:0] req_data1,
  output logic [1:0]      req_ready,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic            busy,
  output logic            owner,
  output logic            done_tick,
  output logic            abort_tick
);

  state_t              state_r;
  logic                owner_r;
  logic                last_owner_r;
  logic                xfer_s;
  logic                cnt_clr_s;
  logic                cnt_tick_s;
  logic                timeout_s;
  logic [TOUT_BIT-1:0] cnt_q_s;

  // Timer only runs through BUSY cycles that move no byte.
  assign cnt_clr_s = (state_r != BUSY) | xfer_s;

  counter #(
    .M(TOUT),
    .N(TOUT_BIT)
  ) u_tout (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr_s),
    .q       (cnt_q_s),
    .max_tick(cnt_tick_s)
  );

  assign timeout_s = cnt_tick_s & (cnt_q_s == TOUT_BIT'(TOUT - 1));

  // Datapath handshake: only the owner sees ready, and only while BUSY.
  always_comb begin
    xfer_s     = 1'b0;
    wr_uart    = 1'b0;
    req_ready  = 2'b00;
    w_data     = {DBIT{1'b0}};
    done_tick  = 1'b0;
    abort_tick = 1'b0;
    case (state_r)
      BUSY: begin
        xfer_s             = req_valid[owner_r] & ~tx_full;
        wr_uart            = xfer_s;
        req_ready[owner_r] = ~tx_full;
        w_data             = owner_r ? req_data1 : req_data0;
        done_tick          = xfer_s & req_last[owner_r];
        abort_tick         = ~xfer_s & timeout_s;
      end
      default: begin
        xfer_s = 1'b0;
      end
    endcase
  end

  // Arbitration FSM: grant in IDLE, release on packet end or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_valid) begin
            owner_r <= rr_pick(req_valid, last_owner_r);
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (done_tick | abort_tick) begin
            state_r      <= IDLE;
            last_owner_r <= owner_r;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_r == BUSY);
  assign owner = owner_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic,
// compared every cycle against a packet-level reference model.
module tb_uart_tx_arb;

  localparam int DBIT     = 8;
  localparam int TOUT     = 16;
  localparam int TOUT_BIT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_last;
  logic [DBIT-1:0] req_data0;
  logic [DBIT-1:0] req_data1;
  logic [1:0]      req_ready;
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            busy;
  logic            owner;
  logic            done_tick;
  logic            abort_tick;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .DBIT(DBIT),
    .TOUT(TOUT),
    .TOUT_BIT(TOUT_BIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .owner     (owner),
    .done_tick (done_tick),
    .abort_tick(abort_tick)
  );

  int checks = 0;
  int errors = 0;

  // client packet queues (pending bytes and their last flags)
  logic [7:0] pk_data [2][$];
  bit         pk_last [2][$];
  bit         gate [2];
  int         hold [2];

  // reference model: who owns the path and how long it has gone without a byte
  bit m_busy;
  bit m_owner;
  bit m_last;
  int m_stall;

  // observation log
  logic [7:0] log_data[$];
  bit         log_own[$];
  int n_done, n_abort, cyc, last_x1, abort_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int c, input int len, input logic [7:0] base, input bit with_last);
    for (int j = 0; j < len; j++) begin
      pk_data[c].push_back(base + 8'(j));
      pk_last[c].push_back(with_last && (j == len - 1));
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_own.delete();
    n_done  = 0;
    n_abort = 0;
  endtask

  task automatic drive();
    logic [1:0] v, l;
    logic [7:0] d [2];
    for (int i = 0; i < 2; i++) begin
      v[i] = gate[i] && (pk_data[i].size() > 0);
      d[i] = v[i] ? pk_data[i][0] : 8'($urandom);
      l[i] = v[i] ? pk_last[i][0] : 1'($urandom);
    end
    req_valid = v;
    req_last  = l;
    req_data0 = d[0];
    req_data1 = d[1];
  endtask

  task automatic step();
    logic [1:0] e_ready;
    logic       e_wr, e_done, e_abort, e_xfer;
    logic [7:0] e_data;
    drive();
    #1;
    e_xfer = 1'b0; e_wr = 1'b0; e_ready = 2'b00; e_done = 1'b0; e_abort = 1'b0; e_data = 8'h00;
    if (m_busy) begin
      e_xfer           = req_valid[m_owner] && !tx_full;
      e_wr             = e_xfer;
      e_ready[m_owner] = !tx_full;
      e_data           = m_owner ? req_data1 : req_data0;
      e_done           = e_xfer && req_last[m_owner];
      e_abort          = !e_xfer && (m_stall == TOUT - 1);
    end
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
    chk("req_ready", req_ready, e_ready);
    chk("wr_uart", wr_uart, e_wr);
    chk("w_data", w_data, e_data);
    chk("done_tick", done_tick, e_done);
    chk("abort_tick", abort_tick, e_abort);
    if (wr_uart) begin
      log_data.push_back(w_data);
      log_own.push_back(owner);
      if (owner) last_x1 = cyc;
    end
    if (done_tick) n_done++;
    if (abort_tick) begin
      n_abort++;
      abort_cyc = cyc;
    end
    @(posedge clk);
    if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_owner = (req_valid == 2'b11) ? !m_last : req_valid[1];
        m_busy  = 1'b1;
        m_stall = 0;
      end
    end else if (e_done || e_abort) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (e_xfer) begin
      m_stall = 0;
    end else begin
      m_stall++;
    end
    if (e_xfer) begin
      void'(pk_data[m_owner].pop_front());
      void'(pk_last[m_owner].pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_idle(input string tag, input int maxn);
    int n = 0;
    while ((m_busy || (gate[0] && pk_data[0].size() > 0) || (gate[1] && pk_data[1].size() > 0))
           && n < maxn) begin
      step();
      n++;
    end
    chk({tag, "_bound"}, 32'(n < maxn), 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_uart", wr_uart, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_done", done_tick, 1'b0);
    chk("rst_abort", abort_tick, 1'b0);
    chk("rst_owner", owner, 1'b0);
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tx_full = 1'b0;
    req_valid = 2'b00; req_last = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
    gate[0] = 1'b1; gate[1] = 1'b1; hold[0] = 0; hold[1] = 0;
    cyc = 0; last_x1 = 0; abort_cyc = 0;
    clear_log();
    @(negedge clk);
    apply_reset();
    step();

    // single client, 3-byte packet
    clear_log();
    push_pkt(0, 3, 8'h41, 1'b1);
    run_idle("s1", 20);
    chk("s1_count", log_data.size(), 3);
    chk("s1_b0", log_data[0], 8'h41);
    chk("s1_b1", log_data[1], 8'h42);
    chk("s1_b2", log_data[2], 8'h43);
    chk("s1_done", n_done, 1);

    // simultaneous requests from reset
    apply_reset();
    clear_log();
    push_pkt(0, 2, 8'hA0, 1'b1);
    push_pkt(1, 2, 8'hB0, 1'b1);
    run_idle("s2", 20);
    chk("s2_own_seq", {log_own[0], log_own[1], log_own[2], log_own[3]}, 4'b0011);
    chk("s2_b2", log_data[2], 8'hB0);
    chk("s2_done", n_done, 2);

    // back-pressure for 5 cycles mid-packet
    clear_log();
    push_pkt(1, 3, 8'hC0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tx_full = (k >= 2 && k <= 6);
      step();
    end
    tx_full = 1'b0;
    chk("s3_count", log_data.size(), 3);
    chk("s3_b1", log_data[1], 8'hC1);
    chk("s3_abort", n_abort, 0);
    chk("s3_done", n_done, 1);

    // stall timeout on client 1, client 0 pending
    clear_log();
    push_pkt(1, 2, 8'hD0, 1'b0);
    step();
    push_pkt(0, 1, 8'hE0, 1'b1);
    run_idle("s4", 60);
    chk("s4_abort", n_abort, 1);
    chk("s4_gap", abort_cyc - last_x1, TOUT);
    chk("s4_own_seq", {log_own[0], log_own[1], log_own[2]}, 3'b110);
    chk("s4_single", log_data[2], 8'hE0);
    chk("s4_done", n_done, 1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (pk_data[i].size() == 0 && $urandom_range(0, 3) == 0)
          push_pkt(i, $urandom_range(1, 4), 8'($urandom), 1'b1);
        if (hold[i] > 0) begin
          gate[i] = 1'b0;
          hold[i]--;
        end else if ($urandom_range(0, 39) == 0) begin
          hold[i] = $urandom_range(10, 25);
          gate[i] = 1'b0;
        end else begin
          gate[i] = ($urandom_range(0, 7) != 0);
        end
      end
      tx_full = ($urandom_range(0, 3) == 0);
      step();
    end
    gate[0] = 1'b1; gate[1] = 1'b1; tx_full = 1'b0;
    run_idle("rnd_drain", 200);

    // reset mid-packet
    clear_log();
    push_pkt(0, 4, 8'h60, 1'b1);
    step();
    step();
    chk("s5_first", log_data.size(), 1);
    apply_reset();
    chk("s5_no_done", n_done, 0);
    chk("s5_no_abort", n_abort, 0);
    for (int i = 0; i < 2; i++) begin
      pk_data[i].delete();
      pk_last[i].delete();
    end
    clear_log();
    push_pkt(0, 1, 8'h70, 1'b1);
    push_pkt(1, 1, 8'h80, 1'b1);
    step();
    chk("s5_prio_owner", owner, 1'b0);
    run_idle("s5", 20);
    chk("s5_own_seq", {log_own[0], log_own[1]}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter DBIT, default 8: data word width; matches the UART w_data width.
REQ-002 Parameter TOUT, default 1024: stall-timeout limit in clk cycles.
REQ-003 Parameter TOUT_BIT, default 10: width of the timeout counter; the relation 2^TOUT_BIT >= TOUT SHALL hold.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 2: per-client byte valid.
REQ-007 Port req_last, input, 2: per-client last-byte-of-packet flag; qualified by req_valid.
REQ-008 Port req_data0 / req_data1, input, DBIT each: per-client byte.
REQ-009 Port req_ready, output, 2: per-client byte accepted this cycle.
REQ-010 Port tx_full, input, 1: UART transmit FIFO full.
REQ-011 Port wr_uart, output, 1: UART transmit FIFO write strobe.
REQ-012 Port w_data, output, DBIT: UART transmit FIFO write data.
REQ-013 Port busy, output, 1: a client currently owns the UART transmit path.
REQ-014 Port owner, output, 1: index of the current or last granted client.
REQ-015 Port done_tick, output, 1: one-cycle pulse when a packet completes.
REQ-016 Port abort_tick, output, 1: one-cycle pulse when a packet is aborted by timeout.

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-018 IDLE, any req_valid high: grant the client chosen by round-robin, register owner, and enter BUSY on the next edge; no byte is transferred in the grant cycle.
REQ-019 Round-robin rule: if both clients are valid, grant ~last_owner; if only one is valid, grant that one. last_owner resets to 1, so client 0 wins the first tie.
REQ-020 BUSY, combinational outputs:
- wr_uart = req_valid[owner] & ~tx_full
- req_ready[owner] = ~tx_full
- req_ready[~owner] = 0
- w_data = data of owner
REQ-021 In IDLE, wr_uart and both req_ready bits SHALL be 0; w_data is don't-care, driven to 0.
REQ-022 Packet completion: a transfer with req_last[owner] high SHALL pulse done_tick in the same cycle and return the FSM to IDLE on the next edge; last_owner <= owner.
REQ-023 A single-byte packet (valid and last on the first BUSY cycle) SHALL complete in one BUSY cycle.
REQ-024 Timeout counter:
- cleared on entry to BUSY and on every transfer
- increments on each BUSY cycle without a transfer, whether the cause is tx_full or an invalid owner
REQ-025 When the counter equals TOUT-1 and no transfer occurs that cycle, the block SHALL pulse abort_tick, return to IDLE, and set last_owner <= owner; no partial byte is written.
REQ-026 A transfer in the same cycle as counter == TOUT-1 SHALL take precedence over the timeout.
REQ-027 Once owned, a packet SHALL never be interleaved with bytes from the other client.
REQ-028 busy SHALL be 1 exactly when the FSM is in BUSY; owner SHALL hold its value in IDLE.

Reset
REQ-029 Reset low SHALL asynchronously force:
- state = IDLE
- owner = 0, last_owner = 1
- timeout counter = 0
- busy = 0, done_tick = 0, abort_tick = 0, wr_uart = 0, req_ready = 0
REQ-030 Reset asserted mid-packet SHALL drop the packet without any completion or abort pulse; after release, arbitration restarts from IDLE.

Structure
REQ-031 A shared package SHALL hold:
- the state encoding: IDLE = 1'b0, BUSY = 1'b1
- the default constants DBIT, TOUT and TOUT_BIT
REQ-032 The timeout SHALL reuse the existing mod-M counter module ("counter", parameters M and N, outputs q and max_tick), with a synchronous clear added. This is the single sub-module; the rest of the logic is flat.

Verification
REQ-033 Single client, no contention: client 0 sends a 3-byte packet 0x41, 0x42, 0x43 (last on 0x43) with tx_full = 0 -> grant after 1 cycle; wr_uart high for 3 consecutive cycles carrying 0x41/0x42/0x43; done_tick on the 0x43 cycle; busy falls on the next edge.
REQ-034 Simultaneous requests, both clients valid from reset with 2-byte packets -> client 0 served first, then client 1; the bytes are never interleaved; owner sequence 0, 1.
REQ-035 Back-pressure: tx_full high for 5 cycles mid-packet -> req_ready and wr_uart held at 0 for those cycles; the byte is held stable; transfer resumes on the first cycle with tx_full = 0; no abort.
REQ-036 Timeout: TOUT = 16; client 1 is granted, then drops valid with no last -> abort_tick exactly 16 BUSY cycles after the last transfer; the FSM returns to IDLE; a pending client 0 is granted next.
REQ-037 Reset mid-packet: reset driven low after the first byte of a 4-byte packet -> busy, wr_uart and req_ready go to 0 immediately (asynchronously); no done_tick or abort_tick; after release, a new request is granted with client 0 having priority.
